// File: rtl/alu_pkg.sv
// Shared opcode, instruction-field and FSM-state definitions for the ALU sequencer.
// Opcode numbering is owned by the alu; the sequencer-only ops sit above it.
package alu_pkg;

   localparam int NREGS = 4;

   localparam logic [3:0] ALU_OP_ADDU = 4'd0;
   localparam logic [3:0] ALU_OP_SUBU = 4'd1;
   localparam logic [3:0] ALU_OP_MULU = 4'd2;
   localparam logic [3:0] ALU_OP_DIVU = 4'd3;
   localparam logic [3:0] ALU_OP_MOD  = 4'd4;
   localparam logic [3:0] ALU_OP_NOT  = 4'd5;
   localparam logic [3:0] ALU_OP_AND  = 4'd6;
   localparam logic [3:0] ALU_OP_OR   = 4'd7;
   localparam logic [3:0] ALU_OP_XOR  = 4'd8;
   localparam logic [3:0] ALU_OP_ADD  = 4'd9;
   localparam logic [3:0] ALU_OP_SUB  = 4'd10;
   localparam logic [3:0] ALU_OP_MUL  = 4'd11;
   localparam logic [3:0] ALU_OP_DIV  = 4'd12;

   localparam logic [3:0] OP_LDI = 4'd13;
   localparam logic [3:0] OP_RDR = 4'd14;
   localparam logic [3:0] OP_ILL = 4'd15;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 10;
   localparam int RS_MSB  = 9;
   localparam int RS_LSB  = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;
   localparam int RT_MSB  = 1;
   localparam int RT_LSB  = 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_RESP = 2'd3
   } seq_state_t;

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == ALU_OP_DIVU) || (op == ALU_OP_MOD) || (op == ALU_OP_DIV);
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response bundle between the CPU front end and the ALU sequencer.
// ALU_SEQ_FLAGS_EN adds the rsp_zero/rsp_neg status flags.
interface alu_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_instr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic        busy;
`ifdef ALU_SEQ_FLAGS_EN
   logic        rsp_zero;
   logic        rsp_neg;
`endif

   modport slave (
      input  cmd_valid, cmd_instr, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
`ifdef ALU_SEQ_FLAGS_EN
      , output rsp_zero, rsp_neg
`endif
   );

   modport master (
      output cmd_valid, cmd_instr, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
`ifdef ALU_SEQ_FLAGS_EN
      , input rsp_zero, rsp_neg
`endif
   );
endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU; every result is truncated to 8 bits.
// A zero divisor yields 0 here; the sequencer flags it as an error.
module alu
   import alu_pkg::*;
(
   input  logic [3:0] alu_op,
   input  logic [7:0] alu_operand1,
   input  logic [7:0] alu_operand2,
   output logic [7:0] alu_out
);

   logic [7:0] w_mag_a;
   logic [7:0] w_mag_b;
   logic [7:0] w_mag_q;
   logic       w_b_zero;

   // Signed divide on magnitudes: |0x80| is 0x80 unsigned, so 0x80 / 0xFF wraps to 0x80.
   assign w_mag_a  = alu_operand1[7] ? (8'd0 - alu_operand1) : alu_operand1;
   assign w_mag_b  = alu_operand2[7] ? (8'd0 - alu_operand2) : alu_operand2;
   assign w_b_zero = (alu_operand2 == 8'd0);
   assign w_mag_q  = w_b_zero ? 8'd0 : (w_mag_a / w_mag_b);

   always_comb begin
      alu_out = 8'd0;
      case (alu_op)
         ALU_OP_ADDU, ALU_OP_ADD: alu_out = alu_operand1 + alu_operand2;
         ALU_OP_SUBU, ALU_OP_SUB: alu_out = alu_operand1 - alu_operand2;
         ALU_OP_MULU, ALU_OP_MUL: alu_out = alu_operand1 * alu_operand2;
         ALU_OP_DIVU: alu_out = w_b_zero ? 8'd0 : (alu_operand1 / alu_operand2);
         ALU_OP_MOD:  alu_out = w_b_zero ? 8'd0 : (alu_operand1 % alu_operand2);
         ALU_OP_NOT:  alu_out = ~alu_operand1;
         ALU_OP_AND:  alu_out = alu_operand1 & alu_operand2;
         ALU_OP_OR:   alu_out = alu_operand1 | alu_operand2;
         ALU_OP_XOR:  alu_out = alu_operand1 ^ alu_operand2;
         ALU_OP_DIV:  alu_out = (alu_operand1[7] ^ alu_operand2[7]) ? (8'd0 - w_mag_q) : w_mag_q;
         default:     alu_out = 8'd0;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback controller around the alu with a private 4x8 register file.
// ALU_SEQ_FLAGS_EN adds registered rsp_zero/rsp_neg outputs.
//
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for an instruction
//   READ   | latched instruction; load operand/op registers from the reg file
//   EXEC   | capture result/error, write back to R[rd]
//   RESP   | response presented until rsp_ready
module alu_sequencer
   import alu_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   alu_sequencer_if.slave bus
);

   seq_state_t r_state;
   seq_state_t w_state_nxt;

   logic [15:0] r_instr;
   logic [7:0]  r_regs [NREGS];
   logic [3:0]  r_alu_op;
   logic [7:0]  r_op1;
   logic [7:0]  r_op2;
   logic [7:0]  r_rsp_data;
   logic        r_rsp_err;
`ifdef ALU_SEQ_FLAGS_EN
   logic        r_rsp_zero;
   logic        r_rsp_neg;
`endif

   logic        w_accept;
   logic [7:0]  w_alu_out;
   logic [7:0]  w_res_data;
   logic        w_res_err;
   logic        w_res_wr;

   assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;

   alu u_alu (
      .alu_op       (r_alu_op),
      .alu_operand1 (r_op1),
      .alu_operand2 (r_op2),
      .alu_out      (w_alu_out)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.cmd_valid) w_state_nxt = S_READ;
         S_READ:  w_state_nxt = S_EXEC;
         S_EXEC:  w_state_nxt = S_RESP;
         S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_res_data = w_alu_out;
      w_res_err  = 1'b0;
      w_res_wr   = 1'b1;
      if (r_alu_op == OP_ILL) begin
         w_res_data = 8'd0;
         w_res_err  = 1'b1;
         w_res_wr   = 1'b0;
      end else if (r_alu_op == OP_LDI) begin
         w_res_data = r_instr[IMM_MSB:IMM_LSB];
      end else if (r_alu_op == OP_RDR) begin
         w_res_data = r_op1;
         w_res_wr   = 1'b0;
      end else if (is_div_op(r_alu_op) && (r_op2 == 8'd0)) begin
         w_res_data = 8'd0;
         w_res_err  = 1'b1;
         w_res_wr   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_instr    <= '0;
         r_alu_op   <= '0;
         r_op1      <= '0;
         r_op2      <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
         r_rsp_zero <= 1'b0;
         r_rsp_neg  <= 1'b0;
`endif
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         if (w_accept) r_instr <= bus.cmd_instr;
         if (r_state == S_READ) begin
            r_alu_op <= r_instr[OP_MSB:OP_LSB];
            r_op1    <= r_regs[r_instr[RS_MSB:RS_LSB]];
            r_op2    <= r_regs[r_instr[RT_MSB:RT_LSB]];
         end
         // The only register-file write point; reset above takes priority over it.
         if (r_state == S_EXEC) begin
            r_rsp_data <= w_res_data;
            r_rsp_err  <= w_res_err;
`ifdef ALU_SEQ_FLAGS_EN
            r_rsp_zero <= !w_res_err && (w_res_data == 8'd0);
            r_rsp_neg  <= !w_res_err && w_res_data[7];
`endif
            if (w_res_wr) r_regs[r_instr[RD_MSB:RD_LSB]] <= w_res_data;
         end
      end
   end

   assign bus.cmd_ready = (r_state == S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.rsp_valid = (r_state == S_RESP);
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_err   = r_rsp_err;
`ifdef ALU_SEQ_FLAGS_EN
   assign bus.rsp_zero  = r_rsp_zero;
   assign bus.rsp_neg   = r_rsp_neg;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer; flag checks compile in with ALU_SEQ_FLAGS_EN.
module tb_alu_sequencer;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   alu_sequencer_if bus();

   alu_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rsp(input string tag, input logic [7:0] exp_data, input logic exp_err);
      chk({tag, " data"}, 16'(bus.rsp_data), 16'(exp_data));
      chk({tag, " err"},  16'(bus.rsp_err),  16'(exp_err));
`ifdef ALU_SEQ_FLAGS_EN
      chk({tag, " zero"}, 16'(bus.rsp_zero), 16'(!exp_err && (exp_data == 8'd0)));
      chk({tag, " neg"},  16'(bus.rsp_neg),  16'(!exp_err && exp_data[7]));
`endif
   endtask

   // Issue one instruction, check 3-cycle latency and the response, optionally stall rsp_ready.
   task automatic run_cmd(input logic [15:0] instr, input logic [7:0] exp_data,
                          input logic exp_err, input int hold, input string tag);
      int lat;
      @(negedge clk);
      chk({tag, " cmd_ready"}, 16'(bus.cmd_ready), 16'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_instr = instr;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_instr = 16'h0000;
      lat = 1;
      while (bus.rsp_valid !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 16'(lat), 16'd3);
      for (int i = 0; i <= hold; i++) begin
         chk_rsp(tag, exp_data, exp_err);
         chk({tag, " rdy/busy/vld"}, {13'd0, bus.cmd_ready, bus.busy, bus.rsp_valid}, 16'b011);
         if (i < hold) @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk({tag, " back idle"}, {13'd0, bus.cmd_ready, bus.busy, bus.rsp_valid}, 16'b100);
   endtask

   initial begin
      // Reset asserted together with a valid command: the command must not be taken.
      rst           = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_instr = 16'hD455;
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset rdy/busy/vld", {13'd0, bus.cmd_ready, bus.busy, bus.rsp_valid}, 16'b100);
      chk_rsp("reset", 8'h00, 1'b0);
      bus.cmd_valid = 1'b0;
      rst           = 1'b0;

      run_cmd(16'hE100, 8'h00, 1'b0, 0, "rdr R1 after rst+cmd");
      run_cmd(16'hD405, 8'h05, 1'b0, 0, "ldi R1");
      run_cmd(16'hD803, 8'h03, 1'b0, 0, "ldi R2");
      run_cmd(16'h1D02, 8'h02, 1'b0, 0, "subu");
      run_cmd(16'h3D00, 8'h00, 1'b1, 0, "divu by zero");
      run_cmd(16'hE300, 8'h02, 1'b0, 0, "rdr R3 kept");
      run_cmd(16'hD4FE, 8'hFE, 1'b0, 0, "ldi R1 fe");
      run_cmd(16'hBD02, 8'hFA, 1'b0, 0, "mul");
      run_cmd(16'h8D02, 8'hFD, 1'b0, 0, "xor");
      run_cmd(16'hF000, 8'h00, 1'b1, 0, "illegal");
      run_cmd(16'hE000, 8'h00, 1'b0, 0, "rdr R0");
      run_cmd(16'hE100, 8'hFE, 1'b0, 0, "rdr R1");
      run_cmd(16'hE200, 8'h03, 1'b0, 0, "rdr R2");
      run_cmd(16'hE300, 8'hFD, 1'b0, 0, "rdr R3");
      run_cmd(16'hD480, 8'h80, 1'b0, 0, "ldi R1 80");
      run_cmd(16'hD8FF, 8'hFF, 1'b0, 0, "ldi R2 ff");
      run_cmd(16'hCD02, 8'h80, 1'b0, 0, "div wrap");
      run_cmd(16'hD000, 8'h00, 1'b0, 0, "ldi R0 zero");
      run_cmd(16'hE300, 8'h80, 1'b0, 5, "stall rdr R3");

      // ADDU R0,R1,R2 interrupted by reset while in EXEC.
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_instr = 16'h0102;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_instr = 16'h0000;
      @(negedge clk);
      chk("exec busy/vld", {14'd0, bus.busy, bus.rsp_valid}, 16'b10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("exec-rst rdy/busy/vld", {13'd0, bus.cmd_ready, bus.busy, bus.rsp_valid}, 16'b100);
      chk_rsp("exec-rst", 8'h00, 1'b0);
      run_cmd(16'hE000, 8'h00, 1'b0, 0, "post-rst R0");
      run_cmd(16'hE100, 8'h00, 1'b0, 0, "post-rst R1");
      run_cmd(16'hE200, 8'h00, 1'b0, 0, "post-rst R2");
      run_cmd(16'hE300, 8'h00, 1'b0, 0, "post-rst R3");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue/writeback controller that drives the 8-bit `alu` from the command side. It accepts 16-bit instruction words over a valid/ready handshake and decodes them into `alu_op`, `alu_operand1` and `alu_operand2`. Operands come from a private 4×8-bit register file, and results are written back there. Each result is returned on a valid/ready response channel, so this block sits between the CPU front end and the combinational ALU.

## Interface
- `NREGS`, 4, register-file depth; fixed at 4 (2-bit indices).
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  instruction word present.
- `cmd_ready`  out  1  block can accept an instruction; high only in IDLE.
- `cmd_instr`  in  16  fields: op[15:12], rd[11:10], rs[9:8], imm[7:0]; rt = imm[1:0].
- `rsp_valid`  out  1  result/status available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  8  result value.
- `rsp_err`  out  1  instruction failed: divide by zero or illegal op.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Ops 0–12 are ALU ops, numbered as in the `alu`: ADDU, SUBU, MULU, DIVU, MOD, NOT, AND, OR, XOR, ADD, SUB, MUL, DIV.
  - operand1 = R[rs]; operand2 = R[rt]; R[rd] ← `alu_out`, truncated to 8 bits.
  - NOT ignores rt.
- Op 13 LDI: R[rd] ← imm; rsp_data = imm; the ALU is not used.
- Op 14 RDR: rsp_data = R[rs]; no register write.
- Op 15 is illegal: rsp_err = 1, rsp_data = 0, no write.
- Ops 3, 4, 12 (DIVU, MOD, DIV) with R[rt] == 0: rsp_err = 1, rsp_data = 0, R[rd] unchanged. The sequencer never presents a zero divisor result as valid.
- Signed DIV of 0x80 / 0xFF returns 0x80 with rsp_err = 0 (two's-complement wrap).
- XOR (op 8) must produce R[rs] ^ R[rt]; the bench checks this explicitly.
- FSM states: IDLE, READ, EXEC, RESP.
  - IDLE → READ on cmd_valid && cmd_ready. The instruction is latched.
  - READ → EXEC. Operands and opcode are registered into the ALU input regs.
  - EXEC → RESP. alu_out is registered, error is evaluated, and writeback to R[rd] happens in this cycle.
  - RESP → IDLE on rsp_ready; otherwise stay in RESP.
- Register-file writes occur only on the EXEC→RESP edge.

## Timing
- Handshake acceptance in cycle N gives rsp_valid high from cycle N+3.
- Writeback is visible to an instruction accepted in cycle N+4 or later, which is the earliest possible acceptance. No hazards can arise.
- With rsp_ready held high, throughput is one instruction per 4 cycles.
- rsp_valid, rsp_data and rsp_err are registered and stay stable while rsp_valid && !rsp_ready.
- cmd_ready is 0 from the acceptance cycle until the cycle after the response handshake.
- Reset values: cmd_ready = 1 (the FSM is in IDLE); rsp_valid = 0, rsp_data = 0, rsp_err = 0, busy = 0; R0–R3 = 0; state = IDLE.
- Reset in any state, including RESP with a pending response: the response is dropped, no partial writeback occurs, and all values return to the reset values on the next edge.
- Simultaneous rst and cmd_valid: reset wins and the command is not accepted.

## Configuration
- `ALU_SEQ_FLAGS_EN` defined: adds outputs `rsp_zero` (rsp_data == 0) and `rsp_neg` (rsp_data[7]).
  - Both are registered with rsp_data, reset to 0, and forced to 0 when rsp_err = 1.
- Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package `alu_pkg`:
  - ALU_OP_* constants 0–12.
  - OP_LDI = 13, OP_RDR = 14, OP_ILL = 15.
  - Instruction field bit positions.
  - FSM state enum.
- The ALU alone updates `alu_pkg` when opcodes change.
- One sub-module: the existing `alu`, instantiated once and fed from the registered operand/op regs.
- Register file and FSM are inline.

## Test plan
- LDI R1,0x05 (0xD405); LDI R2,0x03 (0xD803); SUBU R3,R1,R2 (0x1D02) → rsp_data = 0x05, 0x03, 0x02. rsp_valid appears 3 cycles after each accept.
- DIVU R3,R1,R0 (0x3D00) with R0 = 0 → rsp_err = 1, rsp_data = 0x00; RDR R3 (0xE300) then returns 0x02.
- LDI R1,0xFE (0xD4FE); MUL R3,R1,R2 (0xBD02) → 0xFA. XOR R3,R1,R2 (0x8D02) → 0xFD. With `ALU_SEQ_FLAGS_EN`, rsp_neg = 1.
- Illegal 0xF000 → rsp_err = 1, rsp_data = 0, registers unchanged.
- Hold rsp_ready low for 5 cycles in RESP → rsp_data/rsp_err stable, cmd_ready = 0 and busy = 1 throughout. Release → IDLE on the next cycle.
- Assert rst for 1 cycle during EXEC of ADDU R0,R1,R2 → no writeback; all outputs and R0–R3 read back 0.
